// File: rtl/mult_pkg.sv
// Shared constants for the multiplier datapath.
// The partial-product generator uses the same widths and counts.
package mult_pkg;
  localparam int unsigned PP_NUM = 17;  // Booth partial products per operation
  localparam int unsigned PP_W   = 64;  // partial-product / full product width
  localparam int unsigned RES_W  = 32;  // returned product word width
endpackage

// File: rtl/csa_3to2.sv
// 64-bit bitwise 3:2 carry-save compressor.
// Ports:
//   a, b, c : three addends of width PP_W
//   sum     : bitwise sum (a ^ b ^ c)
//   carry   : majority vector already shifted left one bit; the carry out of
//             the top bit is dropped (all arithmetic is mod 2^PP_W)
module csa_3to2
  import mult_pkg::*;
(
  input  logic [PP_W-1:0] a,
  input  logic [PP_W-1:0] b,
  input  logic [PP_W-1:0] c,
  output logic [PP_W-1:0] sum,
  output logic [PP_W-1:0] carry
);

  always_comb begin
    sum   = a ^ b ^ c;
    carry = {(a[PP_W-2:0] & b[PP_W-2:0]) |
             (a[PP_W-2:0] & c[PP_W-2:0]) |
             (b[PP_W-2:0] & c[PP_W-2:0]), 1'b0};
  end

endmodule

// File: rtl/mult_wallace_tree.sv
// Wallace-tree summation of 17 Booth partial products with a final
// carry-propagate adder; returns the selected 32-bit half of the 64-bit sum.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   pp0..pp16       : registered partial products, pre-shifted to weight
//   pp_valid_i      : partial products valid this cycle
//   res_hi_i        : 1 = return product [63:32], 0 = product [31:0]
//   stall_i         : hold all pipeline state
//   flush_i         : drop all in-flight operations (wins over stall)
//   result_o        : selected product word (holds while not valid)
//   result_valid_o  : result_o valid this cycle
// MID_REG = 1 registers the six vectors after the third CSA level (2-cycle
// latency); MID_REG = 0 omits that register (1-cycle latency).
module mult_wallace_tree
  import mult_pkg::*;
#(
  parameter int unsigned MID_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PP_W-1:0]   pp0,
  input  logic [PP_W-1:0]   pp1,
  input  logic [PP_W-1:0]   pp2,
  input  logic [PP_W-1:0]   pp3,
  input  logic [PP_W-1:0]   pp4,
  input  logic [PP_W-1:0]   pp5,
  input  logic [PP_W-1:0]   pp6,
  input  logic [PP_W-1:0]   pp7,
  input  logic [PP_W-1:0]   pp8,
  input  logic [PP_W-1:0]   pp9,
  input  logic [PP_W-1:0]   pp10,
  input  logic [PP_W-1:0]   pp11,
  input  logic [PP_W-1:0]   pp12,
  input  logic [PP_W-1:0]   pp13,
  input  logic [PP_W-1:0]   pp14,
  input  logic [PP_W-1:0]   pp15,
  input  logic [PP_W-1:0]   pp16,
  input  logic              pp_valid_i,
  input  logic              res_hi_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [RES_W-1:0]  result_o,
  output logic              result_valid_o
);

  // Reduction levels: 17 -> 12 -> 8 -> 6 | 4 -> 3 -> 2
  logic [PP_W-1:0] lv0 [0:PP_NUM-1];
  logic [PP_W-1:0] lv1 [0:11];
  logic [PP_W-1:0] lv2 [0:7];
  logic [PP_W-1:0] lv3 [0:5];
  logic [PP_W-1:0] s1_vec [0:5];
  logic [PP_W-1:0] lv4 [0:3];
  logic [PP_W-1:0] lv5 [0:2];
  logic [PP_W-1:0] lv6 [0:1];
  logic            s1_valid;
  logic            s1_hi;
  logic [PP_W-1:0] prod;
  logic [RES_W-1:0] res_sel;

  assign lv0[0]  = pp0;   assign lv0[1]  = pp1;   assign lv0[2]  = pp2;
  assign lv0[3]  = pp3;   assign lv0[4]  = pp4;   assign lv0[5]  = pp5;
  assign lv0[6]  = pp6;   assign lv0[7]  = pp7;   assign lv0[8]  = pp8;
  assign lv0[9]  = pp9;   assign lv0[10] = pp10;  assign lv0[11] = pp11;
  assign lv0[12] = pp12;  assign lv0[13] = pp13;  assign lv0[14] = pp14;
  assign lv0[15] = pp15;  assign lv0[16] = pp16;

  // Level 1: five CSAs, two vectors pass through
  for (genvar i = 0; i < 5; i++) begin : g_l1
    csa_3to2 u_csa (.a(lv0[3*i]), .b(lv0[3*i+1]), .c(lv0[3*i+2]),
                    .sum(lv1[2*i]), .carry(lv1[2*i+1]));
  end
  assign lv1[10] = lv0[15];
  assign lv1[11] = lv0[16];

  // Level 2: four CSAs
  for (genvar i = 0; i < 4; i++) begin : g_l2
    csa_3to2 u_csa (.a(lv1[3*i]), .b(lv1[3*i+1]), .c(lv1[3*i+2]),
                    .sum(lv2[2*i]), .carry(lv2[2*i+1]));
  end

  // Level 3: two CSAs, two vectors pass through
  for (genvar i = 0; i < 2; i++) begin : g_l3
    csa_3to2 u_csa (.a(lv2[3*i]), .b(lv2[3*i+1]), .c(lv2[3*i+2]),
                    .sum(lv3[2*i]), .carry(lv3[2*i+1]));
  end
  assign lv3[4] = lv2[6];
  assign lv3[5] = lv2[7];

  // Stage 1: optional mid-tree register
  if (MID_REG != 0) begin : g_mid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_hi    <= 1'b0;
        for (int unsigned k = 0; k < 6; k++) s1_vec[k] <= '0;
      end else if (flush_i) begin
        s1_valid <= 1'b0;
      end else if (!stall_i) begin
        s1_valid <= pp_valid_i;
        if (pp_valid_i) begin
          s1_hi <= res_hi_i;
          for (int unsigned k = 0; k < 6; k++) s1_vec[k] <= lv3[k];
        end
      end
    end
  end else begin : g_nomid
    assign s1_valid = pp_valid_i;
    assign s1_hi    = res_hi_i;
    for (genvar k = 0; k < 6; k++) begin : g_pass
      assign s1_vec[k] = lv3[k];
    end
  end

  // Level 4: two CSAs
  for (genvar i = 0; i < 2; i++) begin : g_l4
    csa_3to2 u_csa (.a(s1_vec[3*i]), .b(s1_vec[3*i+1]), .c(s1_vec[3*i+2]),
                    .sum(lv4[2*i]), .carry(lv4[2*i+1]));
  end

  // Level 5: one CSA, one vector passes through
  csa_3to2 u_csa_l5 (.a(lv4[0]), .b(lv4[1]), .c(lv4[2]),
                     .sum(lv5[0]), .carry(lv5[1]));
  assign lv5[2] = lv4[3];

  // Level 6: final CSA
  csa_3to2 u_csa_l6 (.a(lv5[0]), .b(lv5[1]), .c(lv5[2]),
                     .sum(lv6[0]), .carry(lv6[1]));

  always_comb begin
    prod    = lv6[0] + lv6[1];
    res_sel = s1_hi ? prod[PP_W-1:RES_W] : prod[RES_W-1:0];
  end

  // Stage 2: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid_o <= 1'b0;
      result_o       <= '0;
    end else if (flush_i) begin
      result_valid_o <= 1'b0;
    end else if (!stall_i) begin
      result_valid_o <= s1_valid;
      if (s1_valid) result_o <= res_sel;
    end
  end

endmodule

// File: tb/tb_mult_wallace_tree.sv
module tb_mult_wallace_tree;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pp [0:16];
  logic        pp_valid_i, res_hi_i, stall_i, flush_i;
  logic [31:0] r1, r0;
  logic        v1, v0;

  int total = 0;
  int bad   = 0;

  localparam int unsigned NR = 300;
  logic        ev [0:NR+1];
  logic [31:0] er [0:NR+1];

  always #5 clk = ~clk;

  mult_wallace_tree #(.MID_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .pp0(pp[0]), .pp1(pp[1]), .pp2(pp[2]), .pp3(pp[3]), .pp4(pp[4]),
    .pp5(pp[5]), .pp6(pp[6]), .pp7(pp[7]), .pp8(pp[8]), .pp9(pp[9]),
    .pp10(pp[10]), .pp11(pp[11]), .pp12(pp[12]), .pp13(pp[13]),
    .pp14(pp[14]), .pp15(pp[15]), .pp16(pp[16]),
    .pp_valid_i(pp_valid_i), .res_hi_i(res_hi_i), .stall_i(stall_i),
    .flush_i(flush_i), .result_o(r1), .result_valid_o(v1));

  mult_wallace_tree #(.MID_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .pp0(pp[0]), .pp1(pp[1]), .pp2(pp[2]), .pp3(pp[3]), .pp4(pp[4]),
    .pp5(pp[5]), .pp6(pp[6]), .pp7(pp[7]), .pp8(pp[8]), .pp9(pp[9]),
    .pp10(pp[10]), .pp11(pp[11]), .pp12(pp[12]), .pp13(pp[13]),
    .pp14(pp[14]), .pp15(pp[15]), .pp16(pp[16]),
    .pp_valid_i(pp_valid_i), .res_hi_i(res_hi_i), .stall_i(stall_i),
    .flush_i(flush_i), .result_o(r0), .result_valid_o(v0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr_pp();
    for (int i = 0; i < 17; i++) pp[i] = '0;
  endtask

  task automatic rnd_pp();
    for (int i = 0; i < 17; i++) pp[i] = {$urandom, $urandom};
  endtask

  // Reference: plain 64-bit wrap-around sum of all partial products
  function automatic logic [31:0] ref_word(input logic hi);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 17; i++) s = s + pp[i];
    return hi ? s[63:32] : s[31:0];
  endfunction

  logic [31:0] e4, e5, last1, last0;

  initial begin
    rst_n = 1'b0; pp_valid_i = 1'b0; res_hi_i = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0;
    clr_pp();
    #2;
    chk("rst_v1", {31'b0, v1}, 32'd0);
    chk("rst_r1", r1, 32'd0);
    chk("rst_v0", {31'b0, v0}, 32'd0);
    next(); next();
    rst_n = 1'b1;
    next();

    // Test 1: single small operand
    pp[0] = 64'd5; pp_valid_i = 1'b1; res_hi_i = 1'b0;
    next();
    pp_valid_i = 1'b0; clr_pp();
    smp();
    chk("t1_v1_c1", {31'b0, v1}, 32'd0);
    chk("t1_v0_c1", {31'b0, v0}, 32'd1);
    chk("t1_r0_c1", r0, 32'h5);
    next(); smp();
    chk("t1_v1_c2", {31'b0, v1}, 32'd1);
    chk("t1_r1_c2", r1, 32'h5);
    next();

    // Test 2: all ones, low then high word back-to-back
    for (int i = 0; i < 17; i++) pp[i] = '1;
    pp_valid_i = 1'b1; res_hi_i = 1'b0;
    next();
    res_hi_i = 1'b1;
    next();
    pp_valid_i = 1'b0; res_hi_i = 1'b0;
    smp();
    chk("t2_v1_c2", {31'b0, v1}, 32'd1);
    chk("t2_r1_c2", r1, 32'hFFFF_FFEF);
    next(); smp();
    chk("t2_v1_c3", {31'b0, v1}, 32'd1);
    chk("t2_r1_c3", r1, 32'hFFFF_FFFF);
    next();

    // Test 3: wrap-around with carry out dropped
    clr_pp();
    pp[0] = '1; pp[1] = 64'd1; pp[16] = 64'h8000_0000_0000_0000;
    pp_valid_i = 1'b1; res_hi_i = 1'b1;
    next();
    pp_valid_i = 1'b0; clr_pp();
    next(); smp();
    chk("t3_v1", {31'b0, v1}, 32'd1);
    chk("t3_r1", r1, 32'h8000_0000);
    next();

    // Test 4: stall for three cycles after accepting
    rnd_pp(); res_hi_i = 1'b1; pp_valid_i = 1'b1;
    e4 = ref_word(1'b1);
    next();
    for (int c = 1; c <= 3; c++) begin
      stall_i = 1'b1;
      // Upstream would hold; junk here must be ignored while stalled
      pp_valid_i = (c == 2); rnd_pp(); res_hi_i = 1'b0;
      smp();
      chk("t4_stall_v1", {31'b0, v1}, 32'd0);
      chk("t4_stall_r1", r1, 32'h8000_0000);
      next();
    end
    stall_i = 1'b0; pp_valid_i = 1'b0;
    smp();
    chk("t4_v1_c4", {31'b0, v1}, 32'd0);
    next(); smp();
    chk("t4_v1_c5", {31'b0, v1}, 32'd1);
    chk("t4_r1_c5", r1, e4);
    stall_i = 1'b1;
    next(); smp();
    chk("t4_hold_v1", {31'b0, v1}, 32'd1);
    chk("t4_hold_r1", r1, e4);
    stall_i = 1'b0;
    next(); smp();
    chk("t4_v1_c7", {31'b0, v1}, 32'd0);
    next();

    // Test 5: flush with a second op arriving in the flush cycle
    rnd_pp(); pp_valid_i = 1'b1; res_hi_i = 1'b0;
    next();
    rnd_pp(); flush_i = 1'b1;
    next();
    flush_i = 1'b0; pp_valid_i = 1'b0;
    smp();
    chk("t5_v1_c2", {31'b0, v1}, 32'd0);
    next();
    rnd_pp(); pp_valid_i = 1'b1; res_hi_i = 1'b0;
    e5 = ref_word(1'b0);
    smp();
    chk("t5_v1_c3", {31'b0, v1}, 32'd0);
    next();
    pp_valid_i = 1'b0;
    smp();
    chk("t5_v1_c4", {31'b0, v1}, 32'd0);
    chk("t5_r1_c4", r1, e4);
    next(); smp();
    chk("t5_v1_c5", {31'b0, v1}, 32'd1);
    chk("t5_r1_c5", r1, e5);
    next();

    // Test 6: asynchronous reset mid-cycle
    clr_pp(); pp[0] = 64'd7; pp_valid_i = 1'b1; res_hi_i = 1'b0;
    next();
    pp_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_v1", {31'b0, v1}, 32'd0);
    chk("t6_r1", r1, 32'd0);
    chk("t6_v0", {31'b0, v0}, 32'd0);
    chk("t6_r0", r0, 32'd0);
    next(); next();
    rst_n = 1'b1;
    next(); smp();
    chk("t6_post_v1", {31'b0, v1}, 32'd0);
    chk("t6_post_v0", {31'b0, v0}, 32'd0);
    next(); smp();
    chk("t6_post2_v1", {31'b0, v1}, 32'd0);
    next();

    // Random back-to-back run on both latency variants
    last1 = '0; last0 = '0;
    for (int unsigned c = 0; c < NR + 2; c++) begin
      if (c < NR) begin
        rnd_pp();
        if ($urandom_range(0, 7) == 0)
          for (int i = 0; i < 17; i++) pp[i] = '1;
        pp_valid_i = ($urandom_range(0, 3) != 0);
        res_hi_i   = $urandom_range(0, 1) == 1;
      end else begin
        pp_valid_i = 1'b0;
      end
      ev[c] = pp_valid_i;
      er[c] = ref_word(res_hi_i);
      smp();
      if (c >= 1 && ev[c-1]) last0 = er[c-1];
      chk("rnd_v0", {31'b0, v0}, (c >= 1) ? {31'b0, ev[c-1]} : 32'd0);
      chk("rnd_r0", r0, last0);
      if (c >= 2 && ev[c-2]) last1 = er[c-2];
      chk("rnd_v1", {31'b0, v1}, (c >= 2) ? {31'b0, ev[c-2]} : 32'd0);
      chk("rnd_r1", r1, last1);
      next();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_wallace_tree.md
MULT_WALLACE_TREE -- requirements
Module: mult_wallace_tree

Interface
REQ-001 The block SHALL have parameter MID_REG, default 1, meaning: 1 = pipeline register between compression halves (2-cycle latency), 0 = register omitted (1-cycle latency).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports pp0..pp16  input  64 each  registered Booth partial products, already shifted to their weight.
REQ-005 The block SHALL have port pp_valid_i  input  1  pp0..pp16 are valid this cycle.
REQ-006 The block SHALL have port res_hi_i  input  1  aligned with pp_valid_i; 1 = return product bits [63:32], 0 = bits [31:0].
REQ-007 The block SHALL have port stall_i  input  1  hold all pipeline state.
REQ-008 The block SHALL have port flush_i  input  1  discard all in-flight operations.
REQ-009 The block SHALL have port result_o  output  32  selected product word.
REQ-010 The block SHALL have port result_valid_o  output  1  result_o is valid this cycle.

Function
REQ-011 The block SHALL compute S = sum(pp0..pp16) mod 2^64; all additions are 64-bit and carries out of bit 63 are dropped.
REQ-012 The block SHALL reduce the 17 vectors with 3:2 carry-save levels 17->12->8->6->4->3->2; each carry vector is shifted left 1 bit and its bit 63 is dropped.
REQ-013 The block SHALL add the final two vectors with a 64-bit carry-propagate adder; result_o = S[63:32] when the latched res_hi is 1, else S[31:0].
REQ-014 With MID_REG=1, stage 1 SHALL register the 6 vectors after level 3 together with valid and res_hi; stage 2 SHALL register result_o and result_valid_o.
REQ-015 With MID_REG=1, an operation accepted with pp_valid_i=1 in cycle N SHALL appear with result_valid_o=1 in cycle N+2 when no stall occurs. With MID_REG=0, it SHALL appear in cycle N+1.
REQ-016 The block SHALL accept one operation per cycle back-to-back with no bubbles.
REQ-017 While stall_i=1, every pipeline register SHALL hold its value, including result_o and result_valid_o. Input accepted in a stalled cycle SHALL be ignored, because the upstream holds its outputs.
REQ-018 When flush_i=1, all stage valid bits SHALL clear at the next edge, so result_valid_o=0 in the following cycle. Data registers SHALL remain unchanged.
REQ-019 When flush_i and stall_i are both 1, flush SHALL win.
REQ-020 When flush_i and pp_valid_i are both 1, the new operation SHALL be discarded.
REQ-021 Data registers SHALL load only when their incoming valid is 1, to save power. result_o SHALL retain its last value while result_valid_o=0.
REQ-022 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-023 While rst_n=0, all valid bits, res_hi latches, stage-1 vectors and result_o SHALL be 0 asynchronously.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight operations. result_valid_o SHALL be 0 from the first edge after rst_n rises until a new operation completes.

Structure
REQ-025 Shared package mult_pkg SHALL hold PP_NUM=17, PP_W=64 and RES_W=32, which are common with the partial-product generator.
REQ-026 The 64-bit bitwise 3:2 compressor SHALL be sub-module csa_3to2 (inputs a, b, c; outputs sum, carry, carry pre-shifted), instantiated per level via generate.
REQ-027 Stage registers SHALL be written without reset-free flops; every flop SHALL be reset.

Verification
REQ-028 Test 1: pp0=64'd5, others 0, res_hi_i=0, pp_valid_i at cycle 0 -> result_o=32'h5 with result_valid_o=1 at cycle 2 (MID_REG=1).
REQ-029 Test 2: all 17 pp = 64'hFFFF_FFFF_FFFF_FFFF, res_hi_i=0 then same with res_hi_i=1 back-to-back -> 32'hFFFF_FFEF at cycle 2 and 32'hFFFF_FFFF at cycle 3.
REQ-030 Test 3: pp0=64'hFFFF_FFFF_FFFF_FFFF, pp1=64'd1, pp16=64'h8000_0000_0000_0000, res_hi_i=1 -> result_o=32'h8000_0000 (wrap-around, carry out dropped).
REQ-031 Test 4: operation at cycle 0, stall_i=1 in cycles 1-3 -> result_valid_o=1 first at cycle 5 with the correct value; result_o is stable during the stall.
REQ-032 Test 5: operations at cycles 0 and 1, flush_i=1 at cycle 1 -> result_valid_o stays 0 for cycles 2-4; a new operation at cycle 3 completes at cycle 5.
REQ-033 Test 6: rst_n driven low asynchronously mid-cycle at cycle 1 after an operation at cycle 0 -> result_valid_o=0 immediately and result_o=0. Random self-checking run with MID_REG=0 and 1 compares each result against a 64-bit reference sum.
